// File: rtl/rvfi_channel_serializer.sv
// Funnels NRET RVFI retirement channels into one retirement per cycle through a multi-write FIFO.
// Define RVFI_SERIALIZER_ORDER_CHECK_EN to carry rvfi_order per entry and flag sequence gaps.
module rvfi_channel_serializer #(
    parameter int NRET  = 2,
    parameter int XLEN  = 32,
    parameter int ILEN  = 32,
    parameter int DEPTH = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [NRET-1:0]        rvfi_valid,
    input  logic [NRET*ILEN-1:0]   rvfi_insn,
    input  logic [NRET-1:0]        rvfi_trap,
    input  logic [NRET*5-1:0]      rvfi_rs1_addr,
    input  logic [NRET*5-1:0]      rvfi_rs2_addr,
    input  logic [NRET*XLEN-1:0]   rvfi_rs1_rdata,
    input  logic [NRET*XLEN-1:0]   rvfi_rs2_rdata,
    input  logic [NRET*5-1:0]      rvfi_rd_addr,
    input  logic [NRET*XLEN-1:0]   rvfi_rd_wdata,
    input  logic [NRET*XLEN-1:0]   rvfi_pc_rdata,
    input  logic [NRET*XLEN-1:0]   rvfi_pc_wdata,
`ifdef RVFI_SERIALIZER_ORDER_CHECK_EN
    input  logic [NRET*64-1:0]     rvfi_order,
    output logic [63:0]            out_order,
    output logic                   order_error,
`endif
    output logic                   out_valid,
    output logic [ILEN-1:0]        out_insn,
    output logic                   out_trap,
    output logic [4:0]             out_rs1_addr,
    output logic [4:0]             out_rs2_addr,
    output logic [XLEN-1:0]        out_rs1_rdata,
    output logic [XLEN-1:0]        out_rs2_rdata,
    output logic [4:0]             out_rd_addr,
    output logic [XLEN-1:0]        out_rd_wdata,
    output logic [XLEN-1:0]        out_pc_rdata,
    output logic [XLEN-1:0]        out_pc_wdata,
    output logic [$clog2(DEPTH):0] occupancy,
    output logic                   overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
`ifdef RVFI_SERIALIZER_ORDER_CHECK_EN
    localparam int OW = 64;
`else
    localparam int OW = 0;
`endif
    localparam int EW = ILEN + 1 + 5 + 5 + XLEN + XLEN + 5 + XLEN + XLEN + XLEN + OW;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

    logic [PW-1:0] rptr;
    logic [PW-1:0] wptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          overflow_q;
    logic [EW-1:0] mem [DEPTH];
    logic [EW-1:0] entry_in [NRET];
    logic [PW-1:0] slot [NRET];
    logic [CW:0]   k;
    logic [CW:0]   count_sum;
    logic          deq;
    logic          drop;
    logic          accept;
    logic [EW-1:0] head;

    // Each valid channel lands in the slot after all lower-numbered valid channels, so channel 0 is oldest.
    always_comb begin
        k = '0;
        for (int i = 0; i < NRET; i++) begin
            slot[i] = wptr + k[PW-1:0];
            entry_in[i] = {rvfi_insn[i*ILEN +: ILEN], rvfi_trap[i],
                           rvfi_rs1_addr[i*5 +: 5], rvfi_rs2_addr[i*5 +: 5],
                           rvfi_rs1_rdata[i*XLEN +: XLEN], rvfi_rs2_rdata[i*XLEN +: XLEN],
                           rvfi_rd_addr[i*5 +: 5], rvfi_rd_wdata[i*XLEN +: XLEN],
                           rvfi_pc_rdata[i*XLEN +: XLEN], rvfi_pc_wdata[i*XLEN +: XLEN]
`ifdef RVFI_SERIALIZER_ORDER_CHECK_EN
                           , rvfi_order[i*64 +: 64]
`endif
                          };
            k = k + {{CW{1'b0}}, rvfi_valid[i]};
        end
    end

    // A batch is all-or-nothing: if it does not fit after this cycle's dequeue, none of it is kept.
    always_comb begin
        deq        = (count != '0);
        count_sum  = {1'b0, count} - {{CW{1'b0}}, deq} + k;
        drop       = enable && (count_sum > DEPTH_W);
        accept     = enable && !drop;
        count_next = accept ? count_sum[CW-1:0] : (count - {{PW{1'b0}}, deq});
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rptr       <= '0;
            wptr       <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (deq)
                rptr <= rptr + 1'b1;
            if (accept)
                wptr <= wptr + k[PW-1:0];
            count <= count_next;
            if (drop)
                overflow_q <= 1'b1;
        end
    end

    // Storage is not reset; count alone decides which entries are meaningful.
    always_ff @(posedge clock) begin
        if (!reset && accept) begin
            for (int i = 0; i < NRET; i++) begin
                if (rvfi_valid[i])
                    mem[slot[i]] <= entry_in[i];
            end
        end
    end

    assign head = deq ? mem[rptr] : '0;
    assign {out_insn, out_trap, out_rs1_addr, out_rs2_addr, out_rs1_rdata, out_rs2_rdata,
            out_rd_addr, out_rd_wdata, out_pc_rdata, out_pc_wdata
`ifdef RVFI_SERIALIZER_ORDER_CHECK_EN
            , out_order
`endif
           } = head;
    assign out_valid = deq;
    assign occupancy = count;
    assign overflow  = overflow_q;

`ifdef RVFI_SERIALIZER_ORDER_CHECK_EN
    logic [63:0] last_order;
    logic        seen_first;
    logic        order_err_q;
    logic        order_gap;

    // The gap is reported combinationally so the offending entry itself carries the flag.
    assign order_gap   = deq && seen_first && (out_order != last_order + 64'd1);
    assign order_error = order_err_q | order_gap;

    always_ff @(posedge clock) begin
        if (reset) begin
            last_order  <= '0;
            seen_first  <= 1'b0;
            order_err_q <= 1'b0;
        end else begin
            if (deq) begin
                last_order <= out_order;
                seen_first <= 1'b1;
            end
            if (order_gap || drop)
                order_err_q <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_rvfi_channel_serializer.sv
// Directed self-checking bench for rvfi_channel_serializer (default build, NRET=2, DEPTH=8).
module tb_rvfi_channel_serializer;

    logic          clock;
    logic          reset;
    logic          enable;
    logic [1:0]    rvfi_valid;
    logic [63:0]   rvfi_insn;
    logic [1:0]    rvfi_trap;
    logic [9:0]    rvfi_rs1_addr;
    logic [9:0]    rvfi_rs2_addr;
    logic [63:0]   rvfi_rs1_rdata;
    logic [63:0]   rvfi_rs2_rdata;
    logic [9:0]    rvfi_rd_addr;
    logic [63:0]   rvfi_rd_wdata;
    logic [63:0]   rvfi_pc_rdata;
    logic [63:0]   rvfi_pc_wdata;
    logic          out_valid;
    logic [31:0]   out_insn;
    logic          out_trap;
    logic [4:0]    out_rs1_addr;
    logic [4:0]    out_rs2_addr;
    logic [31:0]   out_rs1_rdata;
    logic [31:0]   out_rs2_rdata;
    logic [4:0]    out_rd_addr;
    logic [31:0]   out_rd_wdata;
    logic [31:0]   out_pc_rdata;
    logic [31:0]   out_pc_wdata;
    logic [3:0]    occupancy;
    logic          overflow;

    int total = 0;
    int bad   = 0;
    int exp_occ [8] = '{2, 3, 4, 5, 6, 7, 8, 7};
    int exp_ovf [8] = '{0, 0, 0, 0, 0, 0, 0, 1};

    rvfi_channel_serializer #(.NRET(2), .XLEN(32), .ILEN(32), .DEPTH(8)) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .rvfi_valid(rvfi_valid), .rvfi_insn(rvfi_insn), .rvfi_trap(rvfi_trap),
        .rvfi_rs1_addr(rvfi_rs1_addr), .rvfi_rs2_addr(rvfi_rs2_addr),
        .rvfi_rs1_rdata(rvfi_rs1_rdata), .rvfi_rs2_rdata(rvfi_rs2_rdata),
        .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rd_wdata(rvfi_rd_wdata),
        .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
        .out_valid(out_valid), .out_insn(out_insn), .out_trap(out_trap),
        .out_rs1_addr(out_rs1_addr), .out_rs2_addr(out_rs2_addr),
        .out_rs1_rdata(out_rs1_rdata), .out_rs2_rdata(out_rs2_rdata),
        .out_rd_addr(out_rd_addr), .out_rd_wdata(out_rd_wdata),
        .out_pc_rdata(out_pc_rdata), .out_pc_wdata(out_pc_wdata),
        .occupancy(occupancy), .overflow(overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Loads one channel with a retirement whose side fields are derived from its PC.
    task automatic apply_stimulus(input int ch, input logic [31:0] pc, input logic [31:0] insn);
        rvfi_valid[ch]            = 1'b1;
        rvfi_insn[ch*32 +: 32]     = insn;
        rvfi_pc_rdata[ch*32 +: 32] = pc;
        rvfi_pc_wdata[ch*32 +: 32] = pc + 32'd4;
        rvfi_rd_wdata[ch*32 +: 32] = pc + 32'h1000;
        rvfi_rs1_rdata[ch*32 +: 32] = pc ^ 32'h5555_0000;
        rvfi_rs2_rdata[ch*32 +: 32] = pc ^ 32'h0000_AAAA;
        rvfi_rd_addr[ch*5 +: 5]    = pc[6:2];
        rvfi_rs1_addr[ch*5 +: 5]   = 5'd1;
        rvfi_rs2_addr[ch*5 +: 5]   = 5'd2;
        rvfi_trap[ch]              = 1'b0;
    endtask

    task automatic clear_inputs();
        rvfi_valid = '0; rvfi_insn = '0; rvfi_trap = '0;
        rvfi_rs1_addr = '0; rvfi_rs2_addr = '0; rvfi_rs1_rdata = '0; rvfi_rs2_rdata = '0;
        rvfi_rd_addr = '0; rvfi_rd_wdata = '0; rvfi_pc_rdata = '0; rvfi_pc_wdata = '0;
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_output("rst_valid", 64'(out_valid), 64'd0);
        check_output("rst_occ", 64'(occupancy), 64'd0);
        check_output("rst_ovf", 64'(overflow), 64'd0);
        check_output("rst_insn", 64'(out_insn), 64'd0);
        reset  = 1'b0;
        enable = 1'b1;

        $display("[TB] single retirement");
        apply_stimulus(0, 32'h100, 32'h0050_0093);
        tick();
        clear_inputs();
        check_output("single_valid", 64'(out_valid), 64'd1);
        check_output("single_insn", 64'(out_insn), 64'h0050_0093);
        check_output("single_pc", 64'(out_pc_rdata), 64'h100);
        check_output("single_occ1", 64'(occupancy), 64'd1);
        tick();
        check_output("single_occ0", 64'(occupancy), 64'd0);
        check_output("single_empty", 64'(out_valid), 64'd0);
        check_output("single_zero_pc", 64'(out_pc_rdata), 64'd0);

        $display("[TB] dual retirement");
        apply_stimulus(0, 32'h100, 32'h0000_0013);
        apply_stimulus(1, 32'h104, 32'h0010_0113);
        tick();
        clear_inputs();
        check_output("dual_pc0", 64'(out_pc_rdata), 64'h100);
        check_output("dual_pcw0", 64'(out_pc_wdata), 64'h104);
        check_output("dual_occ2", 64'(occupancy), 64'd2);
        tick();
        check_output("dual_pc1", 64'(out_pc_rdata), 64'h104);
        check_output("dual_insn1", 64'(out_insn), 64'h0010_0113);
        check_output("dual_rd1", 64'(out_rd_wdata), 64'h1104);
        check_output("dual_occ1", 64'(occupancy), 64'd1);
        tick();
        check_output("dual_occ0", 64'(occupancy), 64'd0);

        $display("[TB] fill to exact depth then overflow");
        for (int n = 0; n < 8; n++) begin
            apply_stimulus(0, 32'h200 + 32'(8*n), 32'h13);
            apply_stimulus(1, 32'h204 + 32'(8*n), 32'h13);
            tick();
            check_output($sformatf("ovf_occ%0d", n), 64'(occupancy), 64'(exp_occ[n]));
            check_output($sformatf("ovf_flag%0d", n), 64'(overflow), 64'(exp_ovf[n]));
            check_output($sformatf("ovf_head%0d", n), 64'(out_pc_rdata), 64'(32'h200 + 32'(4*n)));
        end
        clear_inputs();
        for (int j = 1; j < 7; j++) begin
            tick();
            check_output($sformatf("drain_pc%0d", j), 64'(out_pc_rdata), 64'(32'h21C + 32'(4*j)));
            check_output($sformatf("drain_occ%0d", j), 64'(occupancy), 64'(7 - j));
        end
        tick();
        check_output("drain_empty", 64'(out_valid), 64'd0);
        check_output("ovf_sticky", 64'(overflow), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_output("ovf_cleared", 64'(overflow), 64'd0);

        $display("[TB] pointer wrap");
        for (int n = 0; n < 11; n++) begin
            apply_stimulus(0, 32'(4*n), 32'h13);
            tick();
            check_output($sformatf("wrap_pc%0d", n), 64'(out_pc_rdata), 64'(4*n));
            check_output($sformatf("wrap_occ%0d", n), 64'(occupancy), 64'd1);
        end
        clear_inputs();
        tick();
        check_output("wrap_empty", 64'(out_valid), 64'd0);

        $display("[TB] enable low");
        apply_stimulus(0, 32'h300, 32'h13);
        apply_stimulus(1, 32'h304, 32'h13);
        tick();
        clear_inputs();
        enable = 1'b0;
        apply_stimulus(0, 32'h400, 32'h13);
        apply_stimulus(1, 32'h404, 32'h13);
        tick();
        check_output("en_occ1", 64'(occupancy), 64'd1);
        check_output("en_pc", 64'(out_pc_rdata), 64'h304);
        tick();
        check_output("en_occ0", 64'(occupancy), 64'd0);
        check_output("en_ovf", 64'(overflow), 64'd0);
        check_output("en_valid", 64'(out_valid), 64'd0);
        clear_inputs();
        enable = 1'b1;

        $display("[TB] reset mid-drain");
        for (int n = 0; n < 3; n++) begin
            apply_stimulus(0, 32'h500 + 32'(8*n), 32'h13);
            apply_stimulus(1, 32'h504 + 32'(8*n), 32'h13);
            tick();
        end
        clear_inputs();
        check_output("mid_occ4", 64'(occupancy), 64'd4);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_output("mid_occ0", 64'(occupancy), 64'd0);
        check_output("mid_valid", 64'(out_valid), 64'd0);
        check_output("mid_ovf", 64'(overflow), 64'd0);
        apply_stimulus(1, 32'h600, 32'h00A0_0113);
        tick();
        clear_inputs();
        check_output("post_valid", 64'(out_valid), 64'd1);
        check_output("post_pc", 64'(out_pc_rdata), 64'h600);
        check_output("post_insn", 64'(out_insn), 64'h00A0_0113);
        check_output("post_occ", 64'(occupancy), 64'd1);
        tick();
        check_output("post_empty", 64'(occupancy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
